// File: rtl/mic1_shifter.sv
// MIC-1 datapath shifter: sits between the ALU result and the C bus.
// Shift is combinational; Shift_q, N and Z are registered from the shifted value
// and feed microcode branching and debug visibility.
module mic1_shifter (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] ALU_out,
    input  logic [1:0]  SET,
    output logic [31:0] Shift,
    output logic [31:0] Shift_q,
    output logic        N,
    output logic        Z
);

    // Shift-select encodings; 2'b11 is reserved and behaves as pass-through.
    localparam logic [1:0] SelPass = 2'b00;
    localparam logic [1:0] SelSll8 = 2'b01;
    localparam logic [1:0] SelSra1 = 2'b10;

    logic [31:0] shift_d;
    logic [31:0] shift_reg_q;
    logic        n_d;
    logic        n_q;
    logic        z_d;
    logic        z_q;

    // Shift decode; the default arm covers the reserved code and any unknown select.
    always_comb begin
        shift_d = ALU_out;
        case (SET)
            SelPass: shift_d = ALU_out;
            SelSll8: shift_d = {ALU_out[23:0], 8'h00};
            SelSra1: shift_d = {ALU_out[31], ALU_out[31:1]};
            default: shift_d = ALU_out;
        endcase
    end

    // Status flags derive from the post-shift value, not from ALU_out.
    always_comb begin
        n_d = shift_d[31];
        z_d = (shift_d == 32'h0000_0000);
    end

    // Shadow register and flags; asynchronous reset clears them immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shift_reg_q <= 32'h0000_0000;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
        end else begin
            shift_reg_q <= shift_d;
            n_q         <= n_d;
            z_q         <= z_d;
        end
    end

    assign Shift   = shift_d;
    assign Shift_q = shift_reg_q;
    assign N       = n_q;
    assign Z       = z_q;

endmodule

// File: tb/tb_mic1_shifter.sv
// Bench for mic1_shifter: directed vectors plus random stimulus. The driver checks
// the combinational output directly and queues the expected registered state; a
// monitor pops and compares after every rising edge.
module tb_mic1_shifter;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] ALU_out = 32'h0;
    logic [1:0]  SET = 2'b00;
    logic [31:0] Shift;
    logic [31:0] Shift_q;
    logic        N;
    logic        Z;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] val;
        logic        n;
        logic        z;
    } exp_t;

    exp_t sb_q[$];

    mic1_shifter dut (
        .CLK    (CLK),
        .RST    (RST),
        .ALU_out(ALU_out),
        .SET    (SET),
        .Shift  (Shift),
        .Shift_q(Shift_q),
        .N      (N),
        .Z      (Z)
    );

    always #5 CLK = ~CLK;

    // Reference model: shifts expressed as arithmetic on the numeric value.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [1:0] sel);
        longint unsigned wide;
        logic signed [31:0] s;
        case (sel)
            2'b01: begin
                wide = longint'(a) * 256;
                return wide[31:0];
            end
            2'b10: begin
                s = $signed(a);
                return s >>> 1;
            end
            default: return a;
        endcase
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one vector just after a falling edge, check Shift, queue registered expectation.
    task automatic apply(input logic [31:0] a, input logic [1:0] sel, input logic [31:0] want);
        logic [31:0] m;
        @(negedge CLK);
        ALU_out = a;
        SET     = sel;
        #1;
        m = model(a, sel);
        check32("shift_comb", Shift, want);
        sb_q.push_back('{val: m, n: m[31], z: (m == 32'h0)});
    endtask

    // Monitor: after each rising edge, compare registered outputs against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check32("shift_q", Shift_q, e.val);
                check1("n_flag", N, e.n);
                check1("z_flag", Z, e.z);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  sel;
        logic [31:0] hold_val;
        int          drain;

        // Power-on reset pulse, checked asynchronously before any clock edge.
        #2 RST = 1'b1;
        #1;
        check32("reset_shift_q", Shift_q, 32'h0);
        check1("reset_n", N, 1'b0);
        check1("reset_z", Z, 1'b0);
        @(negedge CLK);
        RST = 1'b0;

        // Directed vectors with hand-derived expectations.
        apply(32'hAAAA_AAAA, 2'b00, 32'hAAAA_AAAA);
        apply(32'hAAAA_AAAA, 2'b01, 32'hAAAA_AA00);
        apply(32'h00FF_FFFF, 2'b01, 32'hFFFF_FF00);
        apply(32'hAAAA_AAAA, 2'b10, 32'hD555_5555);
        apply(32'h5555_5555, 2'b10, 32'h2AAA_AAAA);
        apply(32'hFFFF_FFFF, 2'b10, 32'hFFFF_FFFF);
        apply(32'hAAAA_AAAA, 2'b11, 32'hAAAA_AAAA);
        apply(32'hFF00_0000, 2'b01, 32'h0000_0000);
        apply(32'h0000_0001, 2'b10, 32'h0000_0000);
        apply(32'h8000_0000, 2'b00, 32'h8000_0000);

        // Mid-cycle input change: Shift follows, registered outputs hold.
        apply(32'hAAAA_AAAA, 2'b00, 32'hAAAA_AAAA);
        @(posedge CLK);
        #2;
        ALU_out = 32'h0000_0000;
        SET     = 2'b01;
        #1;
        check32("mid_shift", Shift, 32'h0000_0000);
        check32("mid_hold_q", Shift_q, 32'hAAAA_AAAA);
        check1("mid_hold_z", Z, 1'b0);
        check1("mid_hold_n", N, 1'b1);

        // Asynchronous reset between edges, with Shift still tracking inputs.
        ALU_out = 32'hAAAA_AAAA;
        SET     = 2'b10;
        #1;
        RST = 1'b1;
        #1;
        check32("arst_shift_q", Shift_q, 32'h0);
        check1("arst_n", N, 1'b0);
        check1("arst_z", Z, 1'b0);
        check32("arst_shift", Shift, 32'hD555_5555);
        ALU_out = 32'h0000_00FF;
        SET     = 2'b01;
        #1;
        check32("arst_track", Shift, 32'h0000_FF00);
        @(posedge CLK);
        #1;
        check32("arst_edge_q", Shift_q, 32'h0);
        check1("arst_edge_z", Z, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        apply(32'hAAAA_AAAA, 2'b00, 32'hAAAA_AAAA);

        // Random stimulus, biased toward values that exercise the zero flag.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 7))
                0:       a = 32'h0;
                1:       a = {$urandom_range(0, 255), 24'h0};
                2:       a = 32'h1;
                3:       a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            sel = 2'($urandom_range(0, 3));
            hold_val = model(a, sel);
            apply(a, sel, hold_val);
        end

        // Bounded drain of the scoreboard.
        drain = 0;
        while (sb_q.size() > 0 && drain < 4) begin
            @(posedge CLK);
            #2;
            drain++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
